// File: rtl/execute_stage_if.sv
// execute_stage_if
// Bundles the EX stage's pipeline-control inputs (stall/flush), the ID/EX
// latch fields it consumes and the EX/MEM latch fields it produces.
// Ports (modports):
//   slave  : the EX stage; consumes stall, flush and id_ex_*, drives ex_mem_*.
//   master : the surrounding pipeline; drives stall, flush and id_ex_*,
//            observes ex_mem_*.
// Parameters: DATA_W datapath width, REG_AW register-index width.
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Pipeline control
  logic              stall;
  logic              flush;

  // ID/EX latch fields
  logic [1:0]        id_ex_wb;               // {RegWrite, MemtoReg}
  logic [2:0]        id_ex_mem;              // {Branch, MemRead, MemWrite}
  logic [3:0]        id_ex_execute;          // {RegDst, ALUOp[1:0], ALUSrc}
  logic [DATA_W-1:0] id_ex_npc;
  logic [DATA_W-1:0] id_ex_readdat1;
  logic [DATA_W-1:0] id_ex_readdat2;
  logic [DATA_W-1:0] id_ex_sign_ext;
  logic [REG_AW-1:0] id_ex_instr_bits_20_16;
  logic [REG_AW-1:0] id_ex_instr_bits_15_11;

  // EX/MEM latch fields
  logic [1:0]        ex_mem_wb;
  logic [2:0]        ex_mem_mem;
  logic [DATA_W-1:0] ex_mem_branch_target;
  logic              ex_mem_zero;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] ex_mem_write_data;
  logic [REG_AW-1:0] ex_mem_write_reg;
  logic              ex_mem_illegal;

  modport slave (
    input  stall, flush,
    input  id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
    input  id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
    input  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
    output ex_mem_wb, ex_mem_mem, ex_mem_branch_target, ex_mem_zero,
    output ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg,
    output ex_mem_illegal
  );

  modport master (
    output stall, flush,
    output id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
    output id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
    output id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
    input  ex_mem_wb, ex_mem_mem, ex_mem_branch_target, ex_mem_zero,
    input  ex_mem_alu_result, ex_mem_write_data, ex_mem_write_reg,
    input  ex_mem_illegal
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage
// EX stage of the 5-stage MIPS pipeline. Decodes ALU control from ALUOp and
// funct, runs the ALU, computes the branch target, selects the destination
// register and registers everything into the EX/MEM latch (one-cycle latency).
// Ports:
//   clk  : clock, all state updates on the rising edge.
//   rst  : synchronous active-high reset, clears the whole EX/MEM latch.
//   bus  : execute_stage_if.slave -- stall/flush, ID/EX inputs, EX/MEM outputs.
// Edge priority: rst > flush > stall > normal load. A flush zeroes the
// wb/mem/illegal control fields and loads the data fields normally.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_BAD = 3'd5
  } alu_fn_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Decoded control fields
  logic              reg_dst_s;
  logic [1:0]        alu_op_s;
  logic              alu_src_s;
  logic [5:0]        funct_s;
  alu_fn_e           alu_fn_s;

  // Datapath
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              illegal_s;
  logic              zero_s;
  logic [DATA_W-1:0] branch_target_s;
  logic [REG_AW-1:0] write_reg_s;
  logic [1:0]        wb_s;
  logic [2:0]        mem_s;

  // EX/MEM latch
  logic [1:0]        ex_mem_wb_r;
  logic [2:0]        ex_mem_mem_r;
  logic [DATA_W-1:0] ex_mem_branch_target_r;
  logic              ex_mem_zero_r;
  logic [DATA_W-1:0] ex_mem_alu_result_r;
  logic [DATA_W-1:0] ex_mem_write_data_r;
  logic [REG_AW-1:0] ex_mem_write_reg_r;
  logic              ex_mem_illegal_r;

  // Split the execute control bundle and pull funct out of the immediate.
  always_comb begin
    reg_dst_s = bus.id_ex_execute[3];
    alu_op_s  = bus.id_ex_execute[2:1];
    alu_src_s = bus.id_ex_execute[0];
    funct_s   = bus.id_ex_sign_ext[5:0];
  end

  // ALU control: ALUOp selects a fixed op, or defers to funct for R-type.
  always_comb begin
    alu_fn_s = ALU_ADD;
    case (alu_op_s)
      2'b00: alu_fn_s = ALU_ADD;
      2'b01: alu_fn_s = ALU_SUB;
      2'b11: alu_fn_s = ALU_ADD;
      2'b10: begin
        case (funct_s)
          FUNCT_ADD: alu_fn_s = ALU_ADD;
          FUNCT_SUB: alu_fn_s = ALU_SUB;
          FUNCT_AND: alu_fn_s = ALU_AND;
          FUNCT_OR:  alu_fn_s = ALU_OR;
          FUNCT_SLT: alu_fn_s = ALU_SLT;
          default:   alu_fn_s = ALU_BAD;
        endcase
      end
      default: alu_fn_s = ALU_ADD;
    endcase
  end

  // Operand B mux: register rt or the sign-extended immediate.
  always_comb begin
    op_b_s = {DATA_W{1'b0}};
    if (alu_src_s) begin
      op_b_s = bus.id_ex_sign_ext;
    end else begin
      op_b_s = bus.id_ex_readdat2;
    end
  end

  // ALU proper; add/sub wrap modulo 2^DATA_W, unsupported funct yields 0.
  always_comb begin
    alu_result_s = {DATA_W{1'b0}};
    case (alu_fn_s)
      ALU_ADD: alu_result_s = bus.id_ex_readdat1 + op_b_s;
      ALU_SUB: alu_result_s = bus.id_ex_readdat1 - op_b_s;
      ALU_AND: alu_result_s = bus.id_ex_readdat1 & op_b_s;
      ALU_OR:  alu_result_s = bus.id_ex_readdat1 | op_b_s;
      ALU_SLT: alu_result_s = {{(DATA_W-1){1'b0}},
                               ($signed(bus.id_ex_readdat1) < $signed(op_b_s))};
      ALU_BAD: alu_result_s = {DATA_W{1'b0}};
      default: alu_result_s = {DATA_W{1'b0}};
    endcase
  end

  // Flags, branch target, destination select and the illegal-op control kill.
  always_comb begin
    illegal_s       = (alu_fn_s == ALU_BAD);
    // Taken after the illegal override, so an illegal op reports zero=1.
    zero_s          = (alu_result_s == {DATA_W{1'b0}});
    branch_target_s = bus.id_ex_npc + {bus.id_ex_sign_ext[DATA_W-3:0], 2'b00};
    write_reg_s     = {REG_AW{1'b0}};
    if (reg_dst_s) begin
      write_reg_s = bus.id_ex_instr_bits_15_11;
    end else begin
      write_reg_s = bus.id_ex_instr_bits_20_16;
    end
    // An illegal R-type must not write the register file or touch memory.
    wb_s  = 2'b00;
    mem_s = 3'b000;
    if (illegal_s) begin
      wb_s  = 2'b00;
      mem_s = 3'b000;
    end else begin
      wb_s  = bus.id_ex_wb;
      mem_s = bus.id_ex_mem;
    end
  end

  // EX/MEM latch: reset, then flush (bubble), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_wb_r            <= 2'b00;
      ex_mem_mem_r           <= 3'b000;
      ex_mem_branch_target_r <= {DATA_W{1'b0}};
      ex_mem_zero_r          <= 1'b0;
      ex_mem_alu_result_r    <= {DATA_W{1'b0}};
      ex_mem_write_data_r    <= {DATA_W{1'b0}};
      ex_mem_write_reg_r     <= {REG_AW{1'b0}};
      ex_mem_illegal_r       <= 1'b0;
    end else if (bus.flush) begin
      // Bubble: control fields cleared, data fields still load so they stay
      // deterministic.
      ex_mem_wb_r            <= 2'b00;
      ex_mem_mem_r           <= 3'b000;
      ex_mem_branch_target_r <= branch_target_s;
      ex_mem_zero_r          <= zero_s;
      ex_mem_alu_result_r    <= alu_result_s;
      ex_mem_write_data_r    <= bus.id_ex_readdat2;
      ex_mem_write_reg_r     <= write_reg_s;
      ex_mem_illegal_r       <= 1'b0;
    end else if (bus.stall) begin
      ex_mem_wb_r            <= ex_mem_wb_r;
      ex_mem_mem_r           <= ex_mem_mem_r;
      ex_mem_branch_target_r <= ex_mem_branch_target_r;
      ex_mem_zero_r          <= ex_mem_zero_r;
      ex_mem_alu_result_r    <= ex_mem_alu_result_r;
      ex_mem_write_data_r    <= ex_mem_write_data_r;
      ex_mem_write_reg_r     <= ex_mem_write_reg_r;
      ex_mem_illegal_r       <= ex_mem_illegal_r;
    end else begin
      ex_mem_wb_r            <= wb_s;
      ex_mem_mem_r           <= mem_s;
      ex_mem_branch_target_r <= branch_target_s;
      ex_mem_zero_r          <= zero_s;
      ex_mem_alu_result_r    <= alu_result_s;
      ex_mem_write_data_r    <= bus.id_ex_readdat2;
      ex_mem_write_reg_r     <= write_reg_s;
      ex_mem_illegal_r       <= illegal_s;
    end
  end

  assign bus.ex_mem_wb            = ex_mem_wb_r;
  assign bus.ex_mem_mem           = ex_mem_mem_r;
  assign bus.ex_mem_branch_target = ex_mem_branch_target_r;
  assign bus.ex_mem_zero          = ex_mem_zero_r;
  assign bus.ex_mem_alu_result    = ex_mem_alu_result_r;
  assign bus.ex_mem_write_data    = ex_mem_write_data_r;
  assign bus.ex_mem_write_reg     = ex_mem_write_reg_r;
  assign bus.ex_mem_illegal       = ex_mem_illegal_r;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Directed bench for execute_stage. A behavioural model predicts the EX/MEM
// latch every cycle and is compared on the falling edge; directed vectors add
// hand-computed literal checks one cycle after each load.
module tb_execute_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] bt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        ill;
  } exp_t;

  exp_t exp_r;
  logic model_valid;

  execute_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  execute_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level meaning of the ID/EX bundle, written from the ISA rules.
  function automatic exp_t predict();
    exp_t        e;
    logic [31:0] a, b, r;
    logic        reg_dst, alu_src, bad;
    logic [1:0]  aluop;
    reg_dst = bus.id_ex_execute[3];
    aluop   = bus.id_ex_execute[2:1];
    alu_src = bus.id_ex_execute[0];
    a   = bus.id_ex_readdat1;
    b   = alu_src ? bus.id_ex_sign_ext : bus.id_ex_readdat2;
    bad = 1'b0;
    r   = 32'h0;
    if (aluop == 2'b01) r = a - b;
    else if (aluop != 2'b10) r = a + b;
    else begin
      case (bus.id_ex_sign_ext[5:0])
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        default: begin r = 32'h0; bad = 1'b1; end
      endcase
    end
    e.alu  = r;
    e.zero = (r == 32'h0);
    e.ill  = bad;
    e.wb   = bad ? 2'b00 : bus.id_ex_wb;
    e.mem  = bad ? 3'b000 : bus.id_ex_mem;
    e.bt   = bus.id_ex_npc + 32'(bus.id_ex_sign_ext * 4);
    e.wd   = bus.id_ex_readdat2;
    e.wr   = reg_dst ? bus.id_ex_instr_bits_15_11 : bus.id_ex_instr_bits_20_16;
    return e;
  endfunction

  // Model of the latch: reset > flush > stall > load.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      exp_r       <= '0;
      model_valid <= 1'b1;
    end else if (bus.flush) begin
      e = predict();
      e.wb = 2'b00; e.mem = 3'b000; e.ill = 1'b0;
      exp_r <= e;
    end else if (!bus.stall) begin
      exp_r <= predict();
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid === 1'b1) begin
      check("wb",    32'(bus.ex_mem_wb),            32'(exp_r.wb));
      check("mem",   32'(bus.ex_mem_mem),           32'(exp_r.mem));
      check("bt",    bus.ex_mem_branch_target,      exp_r.bt);
      check("zero",  32'(bus.ex_mem_zero),          32'(exp_r.zero));
      check("alu",   bus.ex_mem_alu_result,         exp_r.alu);
      check("wdata", bus.ex_mem_write_data,         exp_r.wd);
      check("wreg",  32'(bus.ex_mem_write_reg),     32'(exp_r.wr));
      check("ill",   32'(bus.ex_mem_illegal),       32'(exp_r.ill));
    end
  end

  task automatic set_in(input logic [3:0] ex, input logic [1:0] wb, input logic [2:0] mem,
                        input logic [31:0] npc, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [4:0] rtf, input logic [4:0] rdf);
    bus.id_ex_execute          = ex;
    bus.id_ex_wb               = wb;
    bus.id_ex_mem              = mem;
    bus.id_ex_npc              = npc;
    bus.id_ex_readdat1         = rs;
    bus.id_ex_readdat2         = rt;
    bus.id_ex_sign_ext         = imm;
    bus.id_ex_instr_bits_20_16 = rtf;
    bus.id_ex_instr_bits_15_11 = rdf;
  endtask

  task automatic step(input logic r, input logic st, input logic fl);
    rst       = r;
    bus.stall = st;
    bus.flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},   32'(bus.ex_mem_wb),        32'h0);
    check({tag, "_mem"},  32'(bus.ex_mem_mem),       32'h0);
    check({tag, "_bt"},   bus.ex_mem_branch_target,  32'h0);
    check({tag, "_zero"}, 32'(bus.ex_mem_zero),      32'h0);
    check({tag, "_alu"},  bus.ex_mem_alu_result,     32'h0);
    check({tag, "_wd"},   bus.ex_mem_write_data,     32'h0);
    check({tag, "_wr"},   32'(bus.ex_mem_write_reg), 32'h0);
    check({tag, "_ill"},  32'(bus.ex_mem_illegal),   32'h0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    model_valid = 1'b0;
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    // Reset with busy, nonzero inputs for two cycles.
    set_in(4'b1100, 2'b10, 3'b010, 32'h44, 32'h5, 32'h3, 32'h20, 5'd3, 5'd4);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all_zero("reset");

    // R-type sub rs=rt=7 -> 0, zero, rd=9.
    set_in(4'b1100, 2'b10, 3'b000, 32'h0, 32'd7, 32'd7, 32'h0000_4822, 5'd7, 5'd9);
    step(1'b0, 1'b0, 1'b0);
    check("sub_alu",  bus.ex_mem_alu_result, 32'h0);
    check("sub_zero", 32'(bus.ex_mem_zero), 32'h1);
    check("sub_wr",   32'(bus.ex_mem_write_reg), 32'd9);
    check("sub_wb",   32'(bus.ex_mem_wb), 32'h2);
    check("sub_ill",  32'(bus.ex_mem_illegal), 32'h0);
    check("model_sub_wr", 32'(exp_r.wr), 32'd9);

    // LW base 0x100 offset -4.
    set_in(4'b0001, 2'b11, 3'b010, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd4, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    check("lw_alu", bus.ex_mem_alu_result, 32'h0000_00FC);
    check("lw_wr",  32'(bus.ex_mem_write_reg), 32'd4);
    check("model_lw_alu", exp_r.alu, 32'h0000_00FC);

    // SW: store data is rt value regardless of ALUSrc.
    set_in(4'b0001, 2'b00, 3'b001, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'h8, 5'd4, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    check("sw_wd",  bus.ex_mem_write_data, 32'hDEAD_BEEF);
    check("sw_alu", bus.ex_mem_alu_result, 32'h0000_0108);

    // BEQ (RegDst=0, ALUOp=01, ALUSrc=0), unequal then equal, then wrap.
    set_in(4'b0010, 2'b00, 3'b100, 32'h20, 32'd5, 32'd6, 32'd3, 5'd6, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    check("beq_bt",   bus.ex_mem_branch_target, 32'h0000_002C);
    check("beq_zero", 32'(bus.ex_mem_zero), 32'h0);
    check("model_beq_bt", exp_r.bt, 32'h0000_002C);
    set_in(4'b0010, 2'b00, 3'b100, 32'h20, 32'd5, 32'd5, 32'd3, 5'd6, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    check("beq_eq_zero", 32'(bus.ex_mem_zero), 32'h1);
    set_in(4'b0010, 2'b00, 3'b100, 32'hFFFF_FFFC, 32'd5, 32'd5, 32'd1, 5'd6, 5'd0);
    step(1'b0, 1'b0, 1'b0);
    check("bt_wrap", bus.ex_mem_branch_target, 32'h0);

    // slt signed: -1 < 1.
    set_in(4'b1100, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0000_182A, 5'd2, 5'd3);
    step(1'b0, 1'b0, 1'b0);
    check("slt_alu", bus.ex_mem_alu_result, 32'h1);
    check("model_slt_alu", exp_r.alu, 32'h1);

    // Unsupported funct 000111: result 0, illegal, control killed.
    set_in(4'b1100, 2'b10, 3'b010, 32'h0, 32'd9, 32'd4, 32'h0000_0007, 5'd2, 5'd3);
    step(1'b0, 1'b0, 1'b0);
    check("bad_alu",  bus.ex_mem_alu_result, 32'h0);
    check("bad_ill",  32'(bus.ex_mem_illegal), 32'h1);
    check("bad_wb",   32'(bus.ex_mem_wb), 32'h0);
    check("bad_mem",  32'(bus.ex_mem_mem), 32'h0);
    check("bad_zero", 32'(bus.ex_mem_zero), 32'h1);

    // ALUOp=11 adds.
    set_in(4'b0110, 2'b10, 3'b000, 32'h0, 32'd10, 32'd20, 32'h0, 5'd8, 5'd1);
    step(1'b0, 1'b0, 1'b0);
    check("op11_alu", bus.ex_mem_alu_result, 32'd30);

    // AND load, then hold for three stalled cycles while inputs move.
    set_in(4'b1100, 2'b10, 3'b000, 32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_4824, 5'd7, 5'd9);
    step(1'b0, 1'b0, 1'b0);
    check("and_alu", bus.ex_mem_alu_result, 32'h0000_F000);
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0110, 2'b01, 3'b001, 32'(i * 16), 32'(i + 1), 32'(i + 100), 32'h0, 5'd1, 5'd2);
      step(1'b0, 1'b1, 1'b0);
      check("stall_alu", bus.ex_mem_alu_result, 32'h0000_F000);
      check("stall_wr",  32'(bus.ex_mem_write_reg), 32'd9);
      check("stall_wd",  bus.ex_mem_write_data, 32'h0000_FF00);
    end

    // Stall and flush together: bubble, data still loads.
    set_in(4'b1100, 2'b11, 3'b010, 32'h0, 32'd1, 32'd2, 32'h0000_4825, 5'd7, 5'd9);
    step(1'b0, 1'b1, 1'b1);
    check("flush_wb",  32'(bus.ex_mem_wb), 32'h0);
    check("flush_mem", 32'(bus.ex_mem_mem), 32'h0);
    check("flush_alu", bus.ex_mem_alu_result, 32'd3);

    // Normal load, then reset beats flush and stall.
    step(1'b0, 1'b0, 1'b0);
    check("pre_rst_wb", 32'(bus.ex_mem_wb), 32'h3);
    step(1'b1, 1'b1, 1'b1);
    check_all_zero("rst_prio");
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_alu", bus.ex_mem_alu_result, 32'd3);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
